// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entry, exception record and scoreboard sizing.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/scoreboard.sv
// In-order issue/commit scoreboard: circular slot buffer with multi-port writeback
// and youngest-first operand forwarding.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  scoreboard_entry_t                           issue_instr_i,
  input  logic                                        issue_valid_i,
  output logic                                        issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    trans_id_o,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_wb_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                wdata_i,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  exception_t [NR_WB_PORTS-1:0]                ex_wb_i,
  output scoreboard_entry_t                           commit_instr_o,
  output logic                                        commit_valid_o,
  input  logic                                        commit_ack_i,
  input  logic [1:0][4:0]                             rs_i,
  output logic [1:0][63:0]                            rs_o,
  output logic [1:0]                                  rs_valid_o,
  output logic [1:0]                                  rs_busy_o
);

  localparam int unsigned CW = TRANS_ID_BITS + 1;

  scoreboard_entry_t        mem_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] issue_ptr_q, commit_ptr_q;
  logic [CW-1:0]            count_q;

  logic [NR_ENTRIES-1:0]    occupied;
  logic [NR_ENTRIES-1:0]    wb_hit;
  logic [63:0]              wb_data [NR_ENTRIES];
  exception_t               wb_ex   [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] offset;
  logic [TRANS_ID_BITS-1:0] idx;
  scoreboard_entry_t        issue_entry;
  logic                     issue_fire, commit_fire;

  // Handshakes: a transfer happens on the cycle where valid and ready are both
  // high; ready never depends on valid, and a flush cancels every transfer.
  assign issue_ready_o  = (count_q < CW'(NR_ENTRIES)) && !flush_i;
  assign trans_id_o     = issue_ptr_q;
  assign commit_instr_o = mem_q[commit_ptr_q];
  assign commit_valid_o = (count_q != '0) && mem_q[commit_ptr_q].valid;
  assign issue_fire     = issue_valid_i && issue_ready_o;
  assign commit_fire    = commit_ack_i && commit_valid_o && !flush_i;

  always_comb begin
    issue_entry          = issue_instr_i;
    issue_entry.trans_id = issue_ptr_q;
    issue_entry.valid    = 1'b0;
  end

  always_comb begin
    offset   = '0;
    occupied = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      offset      = TRANS_ID_BITS'(i) - commit_ptr_q;
      occupied[i] = {1'b0, offset} < count_q;
    end
  end

  // Walk ports from highest to lowest so the lowest index overwrites the rest.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      wb_data[i] = '0;
      wb_ex[i]   = '0;
    end
    for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
      if (wb_valid_i[p]) begin
        wb_hit[trans_id_wb_i[p]]  = 1'b1;
        wb_data[trans_id_wb_i[p]] = wdata_i[p];
        wb_ex[trans_id_wb_i[p]]   = ex_wb_i[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (wb_hit[i] && occupied[i] &&
            !(commit_fire && (TRANS_ID_BITS'(i) == commit_ptr_q))) begin
          mem_q[i].result <= wb_data[i];
          mem_q[i].valid  <= 1'b1;
          if (wb_ex[i].valid) mem_q[i].ex <= wb_ex[i];
        end
      end
      if (issue_fire) begin
        mem_q[issue_ptr_q] <= issue_entry;
        issue_ptr_q        <= issue_ptr_q + 1'b1;
      end
      if (commit_fire) commit_ptr_q <= commit_ptr_q + 1'b1;
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Oldest-to-youngest scan; the last hit (youngest producer) wins.
  always_comb begin
    rs_o       = '0;
    rs_valid_o = '0;
    rs_busy_o  = '0;
    idx        = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        idx = commit_ptr_q + TRANS_ID_BITS'(i);
        if ((CW'(i) < count_q) && (rs_i[k] != 5'd0) && (mem_q[idx].rd == rs_i[k])) begin
          rs_valid_o[k] = mem_q[idx].valid;
          rs_busy_o[k]  = !mem_q[idx].valid;
          rs_o[k]       = mem_q[idx].valid ? mem_q[idx].result : 64'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed scenarios plus random traffic, all checked against
// a queue-based in-order model of the in-flight instructions.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N = NR_SB_ENTRIES;
  localparam int P = NR_WB_PORTS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                              flush;
  scoreboard_entry_t                 issue_instr;
  logic                              issue_valid, issue_ready;
  logic [TRANS_ID_BITS-1:0]          trans_id;
  logic [P-1:0][TRANS_ID_BITS-1:0]   trans_id_wb;
  logic [P-1:0][63:0]                wdata;
  logic [P-1:0]                      wb_valid;
  exception_t [P-1:0]                ex_wb;
  scoreboard_entry_t                 commit_instr;
  logic                              commit_valid, commit_ack;
  logic [1:0][4:0]                   rs;
  logic [1:0][63:0]                  rs_val;
  logic [1:0]                        rs_valid, rs_busy;

  scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_instr_i(issue_instr), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .trans_id_o(trans_id), .trans_id_wb_i(trans_id_wb), .wdata_i(wdata),
    .wb_valid_i(wb_valid), .ex_wb_i(ex_wb), .commit_instr_o(commit_instr),
    .commit_valid_o(commit_valid), .commit_ack_i(commit_ack),
    .rs_i(rs), .rs_o(rs_val), .rs_valid_o(rs_valid), .rs_busy_o(rs_busy)
  );

  // Model: exp_q holds in-flight trans_ids in age order (front = next to commit).
  logic [TRANS_ID_BITS-1:0] exp_q[$];
  logic [TRANS_ID_BITS-1:0] m_next;
  logic [4:0]               m_rd    [N];
  logic [63:0]              m_res   [N];
  logic                     m_done  [N];
  logic                     m_exv   [N];
  logic [63:0]              m_cause [N];
  int tests  = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_occ(input logic [TRANS_ID_BITS-1:0] id);
    foreach (exp_q[j]) if (exp_q[j] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_cv();
    return (exp_q.size() != 0) && m_done[exp_q[0]];
  endfunction

  task automatic m_clear();
    exp_q.delete();
    m_next = '0;
  endtask

  task automatic check_fwd(input int k);
    logic v, b;
    logic [63:0] d;
    v = 1'b0; b = 1'b0; d = '0;
    if (rs[k] != 5'd0) begin
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (m_rd[exp_q[j]] == rs[k]) begin
          v = m_done[exp_q[j]];
          b = !m_done[exp_q[j]];
          d = m_res[exp_q[j]];
          break;
        end
      end
    end
    check($sformatf("rs_valid%0d", k), rs_valid[k], v);
    check($sformatf("rs_busy%0d", k), rs_busy[k], b);
    if (!b) check($sformatf("rs_data%0d", k), rs_val[k], v ? d : 64'd0);
  endtask

  task automatic check_outputs();
    check("issue_ready", issue_ready, (exp_q.size() < N) && !flush);
    check("trans_id", trans_id, m_next);
    check("commit_valid", commit_valid, m_cv());
    if (m_cv()) begin
      check("commit_id", commit_instr.trans_id, exp_q[0]);
      check("commit_rd", commit_instr.rd, m_rd[exp_q[0]]);
      check("commit_result", commit_instr.result, m_res[exp_q[0]]);
      check("commit_exv", commit_instr.ex.valid, m_exv[exp_q[0]]);
      if (m_exv[exp_q[0]]) check("commit_cause", commit_instr.ex.cause, m_cause[exp_q[0]]);
    end
    check_fwd(0);
    check_fwd(1);
  endtask

  task automatic model_update();
    int pre_size;
    bit commit;
    logic [TRANS_ID_BITS-1:0] head;
    logic [N-1:0] written;
    if (flush) begin
      m_clear();
      return;
    end
    pre_size = exp_q.size();
    commit   = commit_ack && m_cv();
    head     = (pre_size != 0) ? exp_q[0] : '0;
    written  = '0;
    for (int p = 0; p < P; p++) begin
      if (wb_valid[p] && m_occ(trans_id_wb[p]) && !written[trans_id_wb[p]] &&
          !(commit && trans_id_wb[p] == head)) begin
        written[trans_id_wb[p]] = 1'b1;
        m_res[trans_id_wb[p]]   = wdata[p];
        m_done[trans_id_wb[p]]  = 1'b1;
        if (ex_wb[p].valid) begin
          m_exv[trans_id_wb[p]]   = 1'b1;
          m_cause[trans_id_wb[p]] = ex_wb[p].cause;
        end
      end
    end
    if (commit) void'(exp_q.pop_front());
    if (issue_valid && pre_size < N) begin
      exp_q.push_back(m_next);
      m_rd[m_next]    = issue_instr.rd;
      m_res[m_next]   = issue_instr.result;
      m_done[m_next]  = 1'b0;
      m_exv[m_next]   = issue_instr.ex.valid;
      m_cause[m_next] = issue_instr.ex.cause;
      m_next          = m_next + 1'b1;
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_instr = '0; wb_valid = '0; trans_id_wb = '0;
    wdata = '0; ex_wb = '0; commit_ack = 1'b0; flush = 1'b0; rs = '0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [63:0] imm);
    issue_valid        = 1'b1;
    issue_instr        = '0;
    issue_instr.rd     = rd;
    issue_instr.result = imm;
    issue_instr.pc     = {32'd0, $urandom};
  endtask

  task automatic set_wb(input int p, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d);
    wb_valid[p] = 1'b1; trans_id_wb[p] = id; wdata[p] = d;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    m_clear();
    rst_n = 1'b0;
    #2;
    check("rst_ready", issue_ready, 1'b1);
    check("rst_commit_valid", commit_valid, 1'b0);
    check("rst_trans_id", trans_id, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all four slots, then try a fifth issue.
    for (int i = 0; i < 4; i++) begin
      #1 check("fill_id", trans_id, i);
      set_issue(5'(i + 1), 64'h100 + i);
      step();
    end
    #1 check("full_ready", issue_ready, 1'b0);
    set_issue(5'd7, 64'hdead);
    step();
    #1 check("full_id_hold", trans_id, 0);

    // Out-of-order writeback on all three ports, in-order commit.
    set_wb(0, 2, 64'hA); set_wb(1, 0, 64'hB); set_wb(2, 1, 64'hC);
    #1 check("head_wait", commit_valid, 1'b0);
    step();
    commit_ack = 1'b1; #1 check("commit_id0", commit_instr.result, 64'hB); step();
    commit_ack = 1'b1; #1 check("commit_id1", commit_instr.result, 64'hC); step();
    commit_ack = 1'b1; #1 check("commit_id2", commit_instr.result, 64'hA); step();
    set_wb(0, 3, 64'hD); step();
    commit_ack = 1'b1; step();

    // Two ports racing for one slot: the lower port wins.
    set_issue(5'd3, 64'h0); step();
    set_issue(5'd4, 64'h0); step();
    set_wb(0, 1, 64'h11); set_wb(2, 1, 64'h22); set_wb(1, 0, 64'h33); step();
    commit_ack = 1'b1; step();
    commit_ack = 1'b1; #1 check("port_priority", commit_instr.result, 64'h11); step();

    // Forwarding from the youngest producer of x5.
    flush = 1'b1; step();
    set_issue(5'd5, 64'h0); step();
    set_issue(5'd5, 64'h0); step();
    set_wb(0, 0, 64'h55); step();
    rs[0] = 5'd5;
    #1 check("fwd_busy", rs_busy[0], 1'b1);
    check("fwd_not_valid", rs_valid[0], 1'b0);
    step();
    set_wb(0, 1, 64'h66); step();
    rs[0] = 5'd5;
    #1 check("fwd_data", rs_val[0], 64'h66);
    check("fwd_valid", rs_valid[0], 1'b1);
    rs[0] = 5'd0;
    #1 check("fwd_x0_valid", rs_valid[0], 1'b0);
    check("fwd_x0_busy", rs_busy[0], 1'b0);
    step();
    flush = 1'b1; step();

    // Pointer wrap, then flush with entries in flight.
    for (int i = 0; i < 6; i++) begin
      set_issue(5'd6, 64'h0); step();
      set_wb(1, 2'(i), 64'h200 + i); step();
      commit_ack = 1'b1; step();
    end
    #1 check("wrap_id", trans_id, 2);
    check("wrap_empty", commit_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_issue(5'd8, 64'h0); step();
    end
    flush = 1'b1; step();
    #1 check("flush_id", trans_id, 0);
    check("flush_commit_valid", commit_valid, 1'b0);
    check("flush_ready", issue_ready, 1'b1);

    // Asynchronous reset with three entries pending.
    for (int i = 0; i < 3; i++) begin
      set_issue(5'(9 + i), 64'h0); step();
    end
    rs[0] = 5'd10;
    #1 check("pre_rst_busy", rs_busy[0], 1'b1);
    rst_n = 1'b0;
    #1 check("arst_ready", issue_ready, 1'b1);
    check("arst_commit_valid", commit_valid, 1'b0);
    check("arst_trans_id", trans_id, 0);
    check("arst_busy", rs_busy[0], 1'b0);
    check("arst_valid", rs_valid[0], 1'b0);
    check("arst_data", rs_val[0], 64'd0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Random traffic.
    repeat (600) begin
      if ($urandom_range(0, 9) < 6) set_issue(5'($urandom_range(0, 7)), {32'd0, $urandom});
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 9) < 4) begin
          set_wb(p, TRANS_ID_BITS'($urandom_range(0, N - 1)), {$urandom, $urandom});
          if ($urandom_range(0, 9) == 0) begin
            ex_wb[p].valid = 1'b1;
            ex_wb[p].cause = {32'd0, $urandom};
          end
        end
      end
      commit_ack = ($urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 39) == 0);
      rs[0]      = 5'($urandom_range(0, 7));
      rs[1]      = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 Parameter NR_ENTRIES, default NR_SB_ENTRIES (4): slot count, power of two.
REQ-002 Parameter NR_WB_PORTS, default NR_WB_PORTS (3): number of writeback ports.
REQ-003 One clock and one reset: reset is asynchronous and active-low.
REQ-004 clk_i  input  1  clock; all state rises on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 flush_i  input  1  discard all in-flight entries.
REQ-007 issue_instr_i  input  scoreboard_entry  decoded instruction to enqueue.
REQ-008 issue_valid_i  input  1  issue request.
REQ-009 issue_ready_o  output  1  slot free, issue accepted.
REQ-010 trans_id_o  output  TRANS_ID_BITS  id the next issued entry receives.
REQ-011 trans_id_wb_i  input  NR_WB_PORTS x TRANS_ID_BITS  writeback target slot per port.
REQ-012 wdata_i  input  NR_WB_PORTS x 64  writeback result per port.
REQ-013 wb_valid_i  input  NR_WB_PORTS  writeback strobe per port.
REQ-014 ex_wb_i  input  NR_WB_PORTS x exception  exception reported with writeback.
REQ-015 commit_instr_o  output  scoreboard_entry  oldest entry.
REQ-016 commit_valid_o  output  1  oldest entry is occupied and finished.
REQ-017 commit_ack_i  input  1  commit stage retires oldest entry.
REQ-018 rs_i  input  2 x 5  operand register addresses (rs1, rs2).
REQ-019 rs_o  output  2 x 64  forwarded operand values.
REQ-020 rs_valid_o / rs_busy_o  output  2 x 1 each  forward available / producer pending.

Function
REQ-021 Circular buffer: issue_ptr, commit_ptr (TRANS_ID_BITS, wrap mod NR_ENTRIES), count (TRANS_ID_BITS+1).
REQ-022 issue_ready_o = (count < NR_ENTRIES) && !flush_i, from registered count only.
- A same-cycle commit does not free a slot for issue.
REQ-023 Issue when issue_valid_i && issue_ready_o:
- write slot[issue_ptr] with trans_id = issue_ptr and valid = 0;
- issue_ptr+1, count+1, next edge.
- Immediate in the result field is preserved until writeback.
REQ-024 trans_id_o = issue_ptr combinationally.
REQ-025 Writeback, per port with wb_valid_i set:
- slot[trans_id_wb_i]: result <= wdata_i, valid <= 1;
- if ex_wb_i.valid, ex <= ex_wb_i.
REQ-026 Multiple ports targeting one slot in one cycle: lowest port index wins.
REQ-027 Writeback to an unoccupied slot is ignored.
REQ-028 commit_instr_o = slot[commit_ptr]; commit_valid_o = (count != 0) && slot[commit_ptr].valid; both from registered state.
REQ-029 commit_ack_i with commit_valid_o: commit_ptr+1, count-1. Ack without commit_valid_o is ignored.
REQ-030 Issue and commit in the same cycle leave count unchanged.
REQ-031 Writeback to the head slot in the same cycle as its commit has no effect on the committed data (slot freed).
REQ-032 flush_i:
- next edge: pointers = 0, count = 0, all slot valid bits = 0;
- issue, writeback and commit_ack in that cycle are ignored.
REQ-033 Forwarding, per operand k, combinational:
- search occupied slots, youngest first, for rd == rs_i[k];
- match with valid = 1: rs_valid_o = 1, rs_busy_o = 0, rs_o = result;
- match with valid = 0: rs_busy_o = 1, rs_valid_o = 0;
- no match, or rs_i[k] == 0: both 0, rs_o = 0.
REQ-034 Same-cycle writebacks are not forwarded; they become visible next cycle.

Reset
REQ-035 On rst_ni low, immediately: pointers, count and all slot contents = 0.
- Outputs: issue_ready_o = 1, commit_valid_o = 0, trans_id_o = 0, rs_* = 0.
REQ-036 Reset mid-operation discards all entries and needs no flush.

Structure
REQ-037 scoreboard_entry, exception, NR_SB_ENTRIES, TRANS_ID_BITS and NR_WB_PORTS are taken from ariane_pkg; no new package types.
REQ-038 Single module, no sub-modules; the forwarding search is an in-module priority loop.

Verification
REQ-039 Issue 4 entries without writeback:
- trans_ids 0,1,2,3;
- issue_ready_o = 0 after the 4th;
- a 5th issue_valid_i is not accepted.
REQ-040 Writeback, ports 0/1/2:
- ids 2,0,1 with data 0xA,0xB,0xC;
- commit order id0 = 0xB, id1 = 0xC, id2 = 0xA;
- commit_valid_o low until the head is written.
REQ-041 Ports 0 and 2 both write id1 (0x11, 0x22) -> committed result 0x11.
REQ-042 Forwarding:
- ids 0,1 both rd = 5; id0 written back 0x55, id1 pending, rs_i[0] = 5 -> rs_busy_o = 1;
- after id1 written back 0x66 -> rs_o = 0x66, rs_valid_o = 1;
- rs_i[0] = 0 -> rs_valid_o = 0, rs_busy_o = 0.
REQ-043 Wrap and flush:
- 6 issue/commit pairs -> pointer wraps to 2, count 0;
- then 3 issues, flush_i -> next cycle count 0, commit_valid_o = 0, trans_id_o = 0.
REQ-044 Assert rst_ni low with 3 entries pending -> all outputs at reset values immediately, no clock edge needed.
